sym_gen: RTL and testbench



---
 rtl/sym_gen_if.sv | 18 +
 rtl/sym_gen.sv | 110 +++++++++++
 tb/tb_sym_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sym_gen_if.sv
// Request/response bundle between the game-period controller (master) and sym_gen (slave).
interface sym_gen_if;
    logic [31:0] symGenMax;
    logic        genSym;
    logic        generated;
    logic        special;
    logic [7:0]  generatedSym;

    modport master (
        output symGenMax, genSym,
        input  generated, special, generatedSym
    );

    modport slave (
        input  symGenMax, genSym,
        output generated, special, generatedSym
    );
endinterface

// File: rtl/sym_gen.sv
// Pseudo-random seven-segment symbol generator: one symbol every symGenMax+1 enabled cycles.
// Optional macro SYMGEN_NO_REPEAT_EN bumps an index equal to the previous one to avoid repeats.
module sym_gen #(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [2:0]  SPECIAL_IDX = 3'd7
) (
    input  logic      Clk100M,
    input  logic      Reset,
    sym_gen_if.slave  bus
);
    // An all-zero Fibonacci LFSR would lock up.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [31:0] cnt_q, cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        gen_q, gen_d;
    logic        spec_q, spec_d;
    logic [7:0]  sym_q, sym_d;

    logic        fb;
    logic [15:0] lfsr_nxt;
    logic [2:0]  raw_idx, fin_idx;
    logic        fire;

    function automatic logic [7:0] seg_code(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h3F;
            3'd1:    return 8'h06;
            3'd2:    return 8'h5B;
            3'd3:    return 8'h4F;
            3'd4:    return 8'h66;
            3'd5:    return 8'h6D;
            3'd6:    return 8'h7D;
            default: return 8'h07;
        endcase
    endfunction

    assign fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_nxt = {lfsr_q[14:0], fb};
    assign raw_idx  = lfsr_nxt[2:0];
    assign fire     = bus.genSym && (cnt_q >= bus.symGenMax);

`ifdef SYMGEN_NO_REPEAT_EN
    logic [2:0] prev_idx_q, prev_idx_d;
    logic       prev_vld_q, prev_vld_d;

    assign fin_idx = (prev_vld_q && raw_idx == prev_idx_q) ? raw_idx + 3'd1 : raw_idx;

    always_comb begin
        prev_idx_d = prev_idx_q;
        prev_vld_d = prev_vld_q;
        if (fire) begin
            prev_idx_d = fin_idx;
            prev_vld_d = 1'b1;
        end
    end

    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            prev_idx_q <= 3'd0;
            prev_vld_q <= 1'b0;
        end else begin
            prev_idx_q <= prev_idx_d;
            prev_vld_q <= prev_vld_d;
        end
    end
`else
    assign fin_idx = raw_idx;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        lfsr_d = lfsr_q;
        gen_d  = 1'b0;
        spec_d = spec_q;
        sym_d  = sym_q;
        if (!bus.genSym) begin
            cnt_d = 32'd0;
        end else if (fire) begin
            cnt_d  = 32'd0;
            lfsr_d = lfsr_nxt;
            sym_d  = seg_code(fin_idx);
            spec_d = (fin_idx == SPECIAL_IDX);
            gen_d  = 1'b1;
        end else begin
            // Never exceeds symGenMax, so no overflow path.
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk100M) begin
        if (Reset) begin
            cnt_q  <= 32'd0;
            lfsr_q <= SEED;
            gen_q  <= 1'b0;
            spec_q <= 1'b0;
            sym_q  <= 8'b0000_0001;
        end else begin
            cnt_q  <= cnt_d;
            lfsr_q <= lfsr_d;
            gen_q  <= gen_d;
            spec_q <= spec_d;
            sym_q  <= sym_d;
        end
    end

    assign bus.generated    = gen_q;
    assign bus.special      = spec_q;
    assign bus.generatedSym = sym_q;
endmodule

// File: tb/tb_sym_gen.sv
// Self-checking bench for sym_gen: directed scenarios plus randomized enable/interval/reset traffic.
module tb_sym_gen;
    logic Clk100M = 1'b0;
    logic Reset   = 1'b1;
    sym_gen_if sif();

    sym_gen dut (.Clk100M(Clk100M), .Reset(Reset), .bus(sif));

    always #5 Clk100M = ~Clk100M;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int NSEQ = 4096;
    logic [7:0] exp_sym  [NSEQ];
    logic       exp_spec [NSEQ];

    // Model state: symbol k of the pre-computed sequence, enabled cycles since last symbol.
    int          m_k;
    longint      m_elapsed;
    logic        m_gen;
    logic        m_spec;
    logic [7:0]  m_sym;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] code_of(input int idx);
        logic [7:0] tab [8];
        tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
        return tab[idx];
    endfunction

    // Whole symbol sequence after reset, derived from the LFSR recurrence.
    task automatic build_seq();
        int s, prev, idx;
        s = 16'hACE1;
        prev = -1;
        for (int k = 0; k < NSEQ; k++) begin
            s = ((s << 1) & 16'hFFFF) | (((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1);
            idx = s % 8;
`ifdef SYMGEN_NO_REPEAT_EN
            if (idx == prev) idx = (idx + 1) % 8;
`endif
            prev = idx;
            exp_sym[k]  = code_of(idx);
            exp_spec[k] = (idx == 7);
        end
    endtask

    // One clock: advance the model from the inputs about to be sampled, then compare.
    task automatic tick();
        if (Reset) begin
            m_k = 0; m_elapsed = 0; m_gen = 1'b0; m_spec = 1'b0; m_sym = 8'h01;
        end else if (!sif.genSym) begin
            m_elapsed = 0; m_gen = 1'b0;
        end else if (m_elapsed >= longint'(sif.symGenMax)) begin
            m_sym = exp_sym[m_k]; m_spec = exp_spec[m_k];
            m_k = (m_k + 1) % NSEQ; m_elapsed = 0; m_gen = 1'b1;
        end else begin
            m_elapsed++; m_gen = 1'b0;
        end
        @(posedge Clk100M);
        #1;
        chk("generated", {31'd0, sif.generated}, {31'd0, m_gen});
        chk("special", {31'd0, sif.special}, {31'd0, m_spec});
        chk("generatedSym", {24'd0, sif.generatedSym}, {24'd0, m_sym});
    endtask

    initial begin
        build_seq();
        m_k = 0; m_elapsed = 0; m_gen = 0; m_spec = 0; m_sym = 8'h01;
        sif.genSym = 1'b1;
        sif.symGenMax = 32'd4;

        // Reset with enable high: nothing may come out.
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gen", {31'd0, sif.generated}, 32'd0);
        end
        chk("rst_sym", {24'd0, sif.generatedSym}, 32'h01);
        chk("rst_spec", {31'd0, sif.special}, 32'd0);

        // symGenMax=4: pulses on the 5th edge, 1 cycle wide.
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("first_wait", {31'd0, sif.generated}, 32'd0);
        end
        tick();
        chk("first_gen", {31'd0, sif.generated}, 32'd1);
        chk("first_sym", {24'd0, sif.generatedSym}, 32'h4F);
        chk("first_spec", {31'd0, sif.special}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("second_wait", {31'd0, sif.generated}, 32'd0);
        end
        tick();
        chk("second_gen", {31'd0, sif.generated}, 32'd1);
        chk("second_sym", {24'd0, sif.generatedSym}, 32'h07);
        chk("second_spec", {31'd0, sif.special}, 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("third_gen", {31'd0, sif.generated}, 32'd1);
`ifdef SYMGEN_NO_REPEAT_EN
        chk("third_sym", {24'd0, sif.generatedSym}, 32'h3F);
        chk("third_spec", {31'd0, sif.special}, 32'd0);
`else
        chk("third_sym", {24'd0, sif.generatedSym}, 32'h07);
        chk("third_spec", {31'd0, sif.special}, 32'd1);
`endif

        // symGenMax=0: continuous generation.
        sif.symGenMax = 32'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("max0_gen", {31'd0, sif.generated}, 32'd1);
        end

        // Drop enable mid-interval; outputs hold, re-enable restarts the interval.
        Reset = 1'b1; tick(); Reset = 1'b0;
        sif.symGenMax = 32'd4;
        for (int i = 0; i < 3; i++) tick();
        sif.genSym = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("drop_gen", {31'd0, sif.generated}, 32'd0);
            chk("drop_sym", {24'd0, sif.generatedSym}, 32'h01);
        end
        sif.genSym = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("reen_wait", {31'd0, sif.generated}, 32'd0);
        end
        tick();
        chk("reen_gen", {31'd0, sif.generated}, 32'd1);
        chk("reen_sym", {24'd0, sif.generatedSym}, 32'h4F);

        // Shrink the limit below the running count.
        sif.symGenMax = 32'd100;
        for (int i = 0; i < 50; i++) tick();
        sif.symGenMax = 32'd2;
        tick();
        chk("shrink_gen", {31'd0, sif.generated}, 32'd1);
        for (int r = 0; r < 3; r++) begin
            tick(); chk("shrink_gap", {31'd0, sif.generated}, 32'd0);
            tick(); chk("shrink_gap", {31'd0, sif.generated}, 32'd0);
            tick(); chk("shrink_gen", {31'd0, sif.generated}, 32'd1);
        end

        // Randomized enable, interval and occasional reset.
        for (int i = 0; i < 2000; i++) begin
            Reset = ($urandom_range(0, 99) == 0);
            sif.genSym = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) sif.symGenMax = $urandom_range(0, 6);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
